// File: rtl/iomem_pkg.sv
// Shared widths, FSM encoding and request bundle for the iomem arbiter.
package iomem_pkg;
  localparam int IOMEM_AW = 32;
  localparam int IOMEM_DW = 32;
  localparam int IOMEM_SW = 4;

  localparam logic [IOMEM_DW-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic [IOMEM_SW-1:0] wstrb;
    logic [IOMEM_AW-1:0] addr;
    logic [IOMEM_DW-1:0] wdata;
  } iomem_req_t;
endpackage

// File: rtl/iomem_arbiter_if.sv
// One picorv32-style iomem channel; master drives the request, slave answers ready/rdata.
interface iomem_arbiter_if;
  import iomem_pkg::*;
  logic                valid;
  logic                ready;
  logic [IOMEM_SW-1:0] wstrb;
  logic [IOMEM_AW-1:0] addr;
  logic [IOMEM_DW-1:0] wdata;
  logic [IOMEM_DW-1:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_watchdog.sv
// Counts BUSY cycles of the current grant and flags the cycle it reaches TIMEOUT-1.
module iomem_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic ck,
  input  logic resetn,
  input  logic busy,
  output logic expire
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Cleared whenever not busy, so each grant starts from 0.
  always_ff @(posedge ck) begin
    if (!resetn || !busy) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign expire = busy && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one iomem slave between CPU (m0) and DSP/DMA (m1).
// Optional grant watchdog enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_arbiter
  import iomem_pkg::*;
#(
  parameter int                  TIMEOUT  = 256,
  parameter logic [IOMEM_DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic             ck,
  input  logic             resetn,
  iomem_arbiter_if.slave   m0,
  iomem_arbiter_if.slave   m1,
  iomem_arbiter_if.master  s,
  output logic             timeout
);
  logic [1:0] state;
  logic       owner, last, s_vld;
  logic [1:0] mv;
  logic       pick, own_vld, busy, expire, done;
  logic [IOMEM_DW-1:0] rsp;
  iomem_req_t req [2];

  assign mv      = {m1.valid, m0.valid};
  assign pick    = (&mv) ? ~last : mv[1];
  assign own_vld = mv[owner];
  assign busy    = (state == ST_BUSY);

  assign req[0] = '{wstrb: m0.wstrb, addr: m0.addr, wdata: m0.wdata};
  assign req[1] = '{wstrb: m1.wstrb, addr: m1.addr, wdata: m1.wdata};

  assign s.valid = s_vld;
  assign s.wstrb = req[owner].wstrb;
  assign s.addr  = req[owner].addr;
  assign s.wdata = req[owner].wdata;

`ifdef IOMEM_ARB_TIMEOUT_EN
  iomem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .ck     (ck),
    .resetn (resetn),
    .busy   (busy),
    .expire (expire)
  );

  always_ff @(posedge ck) begin
    if (!resetn)                               timeout <= 1'b0;
    else if (busy && own_vld && expire && !s.ready) timeout <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT[0];
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Completion is gated by resetn so an aborted transaction never pulses ready.
  assign done = resetn && busy && own_vld && (s.ready || expire);
  assign rsp  = s.ready ? s.rdata : ERR_DATA;

  assign m0.ready = done && !owner;
  assign m1.ready = done &&  owner;
  assign m0.rdata = m0.ready ? rsp : '0;
  assign m1.rdata = m1.ready ? rsp : '0;

  always_ff @(posedge ck) begin
    if (!resetn) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      s_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (|mv) begin
          owner <= pick;
          last  <= pick;
          s_vld <= 1'b1;
          state <= ST_BUSY;
        end
        ST_BUSY: if (!own_vld || s.ready || expire) begin
          s_vld <= 1'b0;
          state <= ST_GAP;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_iomem_arbiter;
  localparam int          TB_TO = 8;
  localparam logic [31:0] ERRV  = 32'hDEADBEEF;
`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic ck = 1'b0;
  logic resetn = 1'b0;
  always #5 ck = ~ck;

  logic [1:0]  mv = 2'b00;
  logic [3:0]  mw [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic        s_rdy = 1'b0;
  logic [31:0] s_rd = 32'h0;
  logic        to_o;

  iomem_arbiter_if m0_if ();
  iomem_arbiter_if m1_if ();
  iomem_arbiter_if s_if ();

  assign m0_if.valid = mv[0];
  assign m0_if.wstrb = mw[0];
  assign m0_if.addr  = ma[0];
  assign m0_if.wdata = md[0];
  assign m1_if.valid = mv[1];
  assign m1_if.wstrb = mw[1];
  assign m1_if.addr  = ma[1];
  assign m1_if.wdata = md[1];
  assign s_if.ready  = s_rdy;
  assign s_if.rdata  = s_rd;

  iomem_arbiter #(.TIMEOUT(TB_TO)) dut (
    .ck      (ck),
    .resetn  (resetn),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .timeout (to_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit chk_en = 1'b0;
  int act_m  = -1;    // master currently holding the bus, -1 = none
  bit gap    = 1'b0;  // dead cycle pending after a transaction
  bit lst    = 1'b1;  // most recent winner
  bit tof    = 1'b0;
  int age    = 0;

  always @(negedge ck) begin
    if (chk_en) begin
      bit ov, expire, dn;
      logic [31:0] rv;
      ov     = (act_m >= 0) && mv[act_m];
      expire = TO_EN && (act_m >= 0) && (age == TB_TO - 1);
      dn     = resetn && ov && (s_rdy || expire);
      rv     = s_rdy ? s_rd : ERRV;
      chk("s_valid", 32'(s_if.valid), 32'(act_m >= 0));
      if (act_m >= 0) begin
        chk("s_addr",  s_if.addr,         ma[act_m]);
        chk("s_wdata", s_if.wdata,        md[act_m]);
        chk("s_wstrb", 32'(s_if.wstrb),   32'(mw[act_m]));
      end
      chk("m0_ready", 32'(m0_if.ready), 32'(dn && act_m == 0));
      chk("m1_ready", 32'(m1_if.ready), 32'(dn && act_m == 1));
      chk("m0_rdata", m0_if.rdata, (dn && act_m == 0) ? rv : 32'h0);
      chk("m1_rdata", m1_if.rdata, (dn && act_m == 1) ? rv : 32'h0);
      chk("timeout",  32'(to_o),   32'(tof));
      if (!resetn) begin
        act_m = -1; gap = 1'b0; lst = 1'b1; tof = 1'b0;
      end else if (act_m >= 0) begin
        if (!ov || s_rdy || expire) begin
          if (ov && !s_rdy && expire) tof = 1'b1;
          act_m = -1;
          gap   = 1'b1;
        end else age++;
      end else if (gap) begin
        gap = 1'b0;
      end else if (mv != 2'b00) begin
        act_m = (mv == 2'b11) ? (lst ? 0 : 1) : (mv[1] ? 1 : 0);
        lst   = (act_m == 1);
        age   = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  int          who, wait_n;
  bit          both_rdy;
  logic [31:0] got0, got1, sawd, sawa;

  task automatic tick();
    @(posedge ck); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; s_rdy = 1'b0; mv = 2'b00;
    tick(); tick();
    resetn = 1'b1;
  endtask

  // Wait for a grant, answer after lat BUSY cycles, record who got ready.
  task automatic serve(input int lat, input logic [31:0] rd, input bit keep);
    wait_n = 0;
    while (!s_if.valid && wait_n < 40) begin tick(); wait_n++; end
    if (!s_if.valid) begin
      chk("serve_grant", 32'(s_if.valid), 32'h1);
      who = -1;
      return;
    end
    repeat (lat - 1) tick();
    s_rdy = 1'b1; s_rd = rd;
    @(negedge ck);
    who      = m0_if.ready ? 0 : (m1_if.ready ? 1 : -1);
    both_rdy = m0_if.ready && m1_if.ready;
    got0 = m0_if.rdata; got1 = m1_if.rdata;
    sawd = s_if.wdata;  sawa = s_if.addr;
    tick();
    s_rdy = 1'b0;
    if (!keep && who >= 0) mv[who] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin mw[i] = '0; ma[i] = '0; md[i] = '0; end
    tick();
    chk_en = 1'b1;
    @(negedge ck);
    chk("rst_s_valid", 32'(s_if.valid), 32'h0);
    chk("rst_m0_ready", 32'(m0_if.ready), 32'h0);
    chk("rst_timeout", 32'(to_o), 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // single m0 write, slave ready on 2nd BUSY cycle
    ma[0] = 32'h03000000; md[0] = 32'h000000A5; mw[0] = 4'hF; mv[0] = 1'b1;
    serve(2, 32'h0, 1'b0);
    chk("wr_arb_latency", 32'(wait_n), 32'd1);
    chk("wr_who", 32'(who), 32'd0);
    chk("wr_s_wdata", sawd, 32'hA5);
    chk("wr_s_addr", sawa, 32'h03000000);
    chk("wr_m1_idle", 32'(both_rdy), 32'h0);
    @(negedge ck);
    chk("wr_ready_1cyc", 32'(m0_if.ready), 32'h0);
    tick();

    // simultaneous requests after reset: m0 then m1
    do_reset();
    ma[1] = 32'h03000010; md[1] = 32'h11; mw[1] = 4'h3;
    mv = 2'b11;
    serve(1, 32'h0, 1'b0);
    chk("tie_first", 32'(who), 32'd0);
    serve(1, 32'h0, 1'b0);
    chk("tie_second", 32'(who), 32'd1);

    // both held valid: strict alternation with a dead gap between grants
    do_reset();
    mv = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve(1 + (i % 2), 32'(i), 1'b1);
      chk("alt_who", 32'(who), 32'(i % 2));
      if (i > 0) chk("alt_gap", 32'(wait_n >= 1), 32'h1);
    end
    mv = 2'b00;
    repeat (3) tick();

    // m1 read
    ma[1] = 32'h03000004; mw[1] = 4'h0; mv[1] = 1'b1;
    serve(3, 32'h12345678, 1'b0);
    chk("rd_who", 32'(who), 32'd1);
    chk("rd_m1_rdata", got1, 32'h12345678);
    chk("rd_m0_rdata", got0, 32'h0);
    repeat (2) tick();

    // reset in the middle of BUSY, with the slave answering in that same cycle
    mv[0] = 1'b1;
    wait_n = 0;
    while (!s_if.valid && wait_n < 20) begin tick(); wait_n++; end
    chk("mid_busy", 32'(s_if.valid), 32'h1);
    resetn = 1'b0; s_rdy = 1'b1; s_rd = 32'hCAFE0001;
    @(negedge ck);
    chk("mid_rst_m0_ready", 32'(m0_if.ready), 32'h0);
    chk("mid_rst_m1_ready", 32'(m1_if.ready), 32'h0);
    tick();
    chk("mid_rst_s_valid", 32'(s_if.valid), 32'h0);
    resetn = 1'b1; s_rdy = 1'b0; mv = 2'b11;
    serve(1, 32'h0, 1'b0);
    chk("post_rst_tie", 32'(who), 32'd0);
    serve(1, 32'h0, 1'b0);
    chk("post_rst_second", 32'(who), 32'd1);
    repeat (2) tick();

`ifdef IOMEM_ARB_TIMEOUT_EN
    // s_ready on the expiry cycle wins
    mw[0] = 4'h0; mv[0] = 1'b1;
    serve(TB_TO, 32'h0BADF00D, 1'b0);
    chk("race_who", 32'(who), 32'd0);
    chk("race_rdata", got0, 32'h0BADF00D);
    @(negedge ck);
    chk("race_no_timeout", 32'(to_o), 32'h0);
    repeat (2) tick();

    // slave never answers
    mv[0] = 1'b1;
    begin
      int busy_n, n;
      busy_n = 0; n = 0;
      while (n < 40) begin
        @(negedge ck);
        if (s_if.valid) busy_n++;
        if (m0_if.ready) break;
        n++;
      end
      chk("to_ready_seen", 32'(m0_if.ready), 32'h1);
      chk("to_busy_cycles", 32'(busy_n), 32'd8);
      chk("to_rdata", m0_if.rdata, 32'hDEADBEEF);
    end
    tick();
    mv[0] = 1'b0;
    repeat (5) tick();
    @(negedge ck);
    chk("to_sticky", 32'(to_o), 32'h1);
    tick();
`endif

    // random traffic
    begin
      bit r0, r1, sv, pend;
      int dly;
      int maxl;
      maxl = TO_EN ? 9 : 3;
      pend = 1'b0; dly = 0;
      for (int c = 0; c < 4000; c++) begin
        @(negedge ck);
        r0 = m0_if.ready; r1 = m1_if.ready; sv = s_if.valid;
        tick();
        resetn = ($urandom_range(0, 299) != 0);
        for (int i = 0; i < 2; i++) begin
          bit rr;
          rr = (i == 0) ? r0 : r1;
          if (mv[i] && rr) begin
            mv[i] = ($urandom_range(0, 2) == 0);
            if (mv[i]) begin
              ma[i] = $urandom; md[i] = $urandom;
              mw[i] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            end
          end else if (mv[i]) begin
            if ($urandom_range(0, 99) == 0) mv[i] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            mv[i] = 1'b1;
            ma[i] = $urandom; md[i] = $urandom;
            mw[i] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
          end
        end
        if (s_rdy) begin
          s_rdy = 1'b0; pend = 1'b0;
        end else if (sv) begin
          if (!pend) begin pend = 1'b1; dly = $urandom_range(0, maxl); end
          if (dly == 0) begin s_rdy = 1'b1; s_rd = $urandom; end
          else dly--;
        end else pend = 1'b0;
      end
    end

    mv = 2'b00; s_rdy = 1'b0; resetn = 1'b1;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
